// File: rtl/display_pkg.sv
// display_pkg: shared types, segment constants and the hex segment table for the display driver
package display_pkg;
  typedef enum logic [1:0] {HEX = 2'd0, UDEC = 2'd1, SDEC = 2'd2} mode_t;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    return SEG_TAB[n];
  endfunction
endpackage

// File: rtl/display_dec_seg7_decode.sv
// seg7_decode: one hex nibble to active-low gfedcba segments
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = hex_to_seg(i_nib);
endmodule

// File: rtl/display_dec.sv
// display_dec: bus-captured hex/decimal 7-segment driver with serial double-dabble conversion
module display_dec #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              outputEN,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        mode,
  input  logic              blank_lz,
  output logic              busy,
  output logic [6:0]        disp [DIGITS]
);
  import display_pkg::*;
  localparam int NIB = (DATA_W + 3) / 4;
  localparam int NP = DIGITS > NIB ? DIGITS : NIB;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W);
  state_t r_state, w_next;
  mode_t r_mode, w_mode;
  logic r_blz, r_neg, r_ovf, r_pv, r_pblz, w_use_p, w_cap, w_blz, w_ovf;
  logic [1:0] r_pmode, w_mraw;
  logic [DATA_W-1:0] r_mag, r_pdata, w_data, w_mag;
  logic [BW-1:0] r_bcd, w_adj;
  logic [CW-1:0] r_cnt;
  logic [4*NP-1:0] w_pad;
  logic [DIGITS:0] w_zf;
  logic [3:0] w_nib [DIGITS];
  logic [6:0] w_fmt [DIGITS];
  logic [6:0] r_disp [DIGITS];
  // in DONE a live write beats the pending one; either way it is captured like an IDLE write
  always_comb begin
    w_use_p = r_state == DONE && !outputEN;
    w_cap = (r_state == IDLE && outputEN) || (r_state == DONE && (outputEN || r_pv));
    w_data = w_use_p ? r_pdata : data;
    w_mraw = w_use_p ? r_pmode : mode;
    w_blz = w_use_p ? r_pblz : blank_lz;
    w_mode = w_mraw == 2'b01 ? UDEC : w_mraw == 2'b10 ? SDEC : HEX;
    w_mag = (w_mode == SDEC && w_data[DATA_W-1]) ? DATA_W'(-{1'b1, w_data}) : w_data;
    w_next = w_cap ? (w_mode == HEX ? DONE : CONV) :
             r_state == DONE ? IDLE :
             (r_state == CONV && r_cnt == CW'(DATA_W - 1)) ? DONE : r_state;
  end
  always_comb begin
    w_adj = r_bcd;
    w_pad = '0;
    w_pad[DATA_W-1:0] = r_mag;
    w_nib = '{default: 4'd0};
    w_ovf = r_ovf;
    w_zf = '1;
    for (int k = 0; k < DIGITS; k++) begin
      w_adj[4*k+:4] = r_bcd[4*k+:4] >= 4'd5 ? r_bcd[4*k+:4] + 4'd3 : r_bcd[4*k+:4];
      w_nib[k] = r_mode == HEX ? w_pad[4*k+:4] : r_bcd[4*k+:4];
    end
    for (int k = DIGITS; k < NP; k++) w_ovf = w_ovf || (r_mode == HEX && w_pad[4*k+:4] != 4'd0);
    w_ovf = w_ovf || (r_neg && w_nib[DIGITS-1] != 4'd0);
    for (int k = DIGITS - 1; k >= 0; k--) w_zf[k] = w_zf[k+1] && w_nib[k] == 4'd0;
  end
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [6:0] w_seg;
    logic w_lz, w_first;
    seg7_decode u_seg (.i_nib(w_nib[g]), .o_seg(w_seg));
    if (g == 0) begin : g_lo
      assign w_lz = 1'b0;
      assign w_first = 1'b0;
    end else begin : g_hi
      assign w_lz = w_zf[g];
      assign w_first = w_zf[g] && !w_zf[g-1];
    end
    assign w_fmt[g] = (w_ovf || (r_neg && (r_blz ? w_first : g == DIGITS - 1))) ? SEG_MINUS :
                      (r_blz && w_lz) ? SEG_BLANK : w_seg;
  end
  always_ff @(posedge CLK) r_state <= RST ? IDLE : w_next;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pv <= 1'b0;
      r_ovf <= 1'b0;
      r_neg <= 1'b0;
      for (int k = 0; k < DIGITS; k++) r_disp[k] <= SEG_ZERO;
    end else begin
      if (r_state == CONV && outputEN) begin
        r_pv <= 1'b1;
        r_pdata <= data;
        r_pmode <= mode;
        r_pblz <= blank_lz;
      end else if (r_state == DONE) begin
        r_pv <= 1'b0;
      end
      if (w_cap) begin
        r_mode <= w_mode;
        r_blz <= w_blz;
        r_mag <= w_mag;
        r_neg <= w_mode == SDEC && w_data[DATA_W-1];
        r_ovf <= 1'b0;
        r_bcd <= '0;
        r_cnt <= '0;
      end else if (r_state == CONV) begin
        r_bcd <= {w_adj[BW-2:0], r_mag[DATA_W-1]};
        r_mag <= r_mag << 1;
        r_ovf <= r_ovf || w_adj[BW-1];
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == DONE) r_disp <= w_fmt;
    end
  end
  assign busy = r_state != IDLE;
  assign disp = r_disp;
endmodule

// File: tb/tb_display_dec.sv
// tb_display_dec: randomized and directed check of display_dec against an arithmetic reference model
module tb_display_dec;
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic clk, rst, en, blz, busy4, busy2;
  logic [7:0] data;
  logic [1:0] mode;
  logic [6:0] d4 [4];
  logic [6:0] d2 [2];
  int checks = 0, errors = 0;
  display_dec #(.DATA_W(8), .DIGITS(4)) u_dut4 (.CLK(clk), .RST(rst), .outputEN(en), .data(data),
    .mode(mode), .blank_lz(blz), .busy(busy4), .disp(d4));
  display_dec #(.DATA_W(8), .DIGITS(2)) u_dut2 (.CLK(clk), .RST(rst), .outputEN(en), .data(data),
    .mode(mode), .blank_lz(blz), .busy(busy2), .disp(d2));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  function automatic logic [27:0] model(input logic [7:0] d, input logic [1:0] m, input logic bz, input int nd);
    int base, mag, top, pos;
    int dg [5];
    logic neg, ovf;
    logic [27:0] r;
    base = (m == 2'd1 || m == 2'd2) ? 10 : 16;
    neg = m == 2'd2 && d[7];
    mag = neg ? 256 - int'(d) : int'(d);
    ovf = mag >= base ** nd;
    top = 0;
    dg = '{default: 0};
    for (int i = 0; i < nd; i++) begin
      dg[i] = (mag / (base ** i)) % base;
      if (dg[i] != 0) top = i;
    end
    pos = bz ? top + 1 : nd - 1;
    if (neg && (pos >= nd || dg[pos] != 0)) ovf = 1'b1;
    r = '0;
    for (int i = 0; i < nd; i++)
      r[7*i+:7] = (ovf || (neg && i == pos)) ? 7'h3F : (bz && i > top) ? 7'h7F : SEG[dg[i]];
    return r;
  endfunction
  logic m_ready = 1'b0, m_active, m_pv, jb, pb;
  logic [7:0] jd, pd;
  logic [1:0] jm, pm;
  int m_rem;
  logic [27:0] m_d4, m_d2;
  task automatic start(input logic [7:0] d, input logic [1:0] m, input logic b);
    jd = d; jm = m; jb = b;
    m_rem = (m == 2'd1 || m == 2'd2) ? 9 : 1;
    m_active = 1'b1;
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b1;
      m_active = 1'b0;
      m_pv = 1'b0;
      m_d4 = {4{7'b1000000}};
      m_d2 = {14'b0, {2{7'b1000000}}};
    end else if (!m_active) begin
      if (en) start(data, mode, blz);
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_d4 = model(jd, jm, jb, 4);
        m_d2 = model(jd, jm, jb, 2);
        if (en) start(data, mode, blz);
        else if (m_pv) start(pd, pm, pb);
        else m_active = 1'b0;
        m_pv = 1'b0;
      end else if (en) begin
        m_pv = 1'b1; pd = data; pm = mode; pb = blz;
      end
    end
  end
  always @(negedge clk) begin
    if (m_ready) begin
      chk("busy4", 28'(busy4), 28'(m_active));
      chk("busy2", 28'(busy2), 28'(m_active));
      chk("disp4", {d4[3], d4[2], d4[1], d4[0]}, m_d4);
      chk("disp2", {14'b0, d2[1], d2[0]}, m_d2);
    end
  end
  task automatic wr(input logic [7:0] d, input logic [1:0] m, input logic b);
    en = 1'b1; data = d; mode = m; blz = b;
    @(negedge clk);
    en = 1'b0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy4 && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) chk("idle_timeout", 28'(busy4), 28'd0);
  endtask
  initial begin
    int n;
    logic saw10, bad20;
    rst = 1'b1; en = 1'b0; data = '0; mode = '0; blz = 1'b0;
    chk("model_3C", model(8'h3C, 2'd0, 1'b0, 4), {7'h40, 7'h40, 7'h30, 7'h27});
    chk("model_255", model(8'd255, 2'd1, 1'b1, 4), {7'h7F, 7'h24, 7'h12, 7'h12});
    chk("model_80", model(8'h80, 2'd2, 1'b1, 4), {7'h3F, 7'h79, 7'h24, 7'h00});
    chk("model_F6_2", model(8'hF6, 2'd2, 1'b1, 2), {14'b0, 7'h3F, 7'h3F});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_disp", {d4[3], d4[2], d4[1], d4[0]}, {4{7'b1000000}});
    chk("reset_busy", 28'(busy4), 28'd0);
    wr(8'h3C, 2'd0, 1'b0);
    chk("hex_busy_hi", 28'(busy4), 28'd1);
    @(negedge clk);
    chk("hex_busy_lo", 28'(busy4), 28'd0);
    chk("hex_3C", {d4[3], d4[2], d4[1], d4[0]}, {7'h40, 7'h40, 7'h30, 7'h27});
    wr(8'd255, 2'd1, 1'b1);
    wait_idle(n);
    chk("udec_busy_len", 28'(n), 28'd9);
    chk("udec_255", {d4[3], d4[2], d4[1], d4[0]}, {7'h7F, 7'h24, 7'h12, 7'h12});
    wr(8'h80, 2'd2, 1'b1);
    wait_idle(n);
    chk("sdec_80", {d4[3], d4[2], d4[1], d4[0]}, {7'h3F, 7'h79, 7'h24, 7'h00});
    wr(8'hFF, 2'd2, 1'b1);
    wait_idle(n);
    chk("sdec_FF", {d4[3], d4[2], d4[1], d4[0]}, {7'h7F, 7'h7F, 7'h3F, 7'h79});
    wr(8'd10, 2'd1, 1'b0);
    wr(8'd20, 2'd1, 1'b0);
    wr(8'd30, 2'd1, 1'b0);
    saw10 = 1'b0; bad20 = 1'b0; n = 0;
    while (busy4 && n < 60) begin
      if (d4[1] == 7'h24) bad20 = 1'b1;
      if (d4[1] == 7'h79) saw10 = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("b2b_busy_len", 28'(n), 28'd16);
    chk("b2b_saw10", 28'(saw10), 28'd1);
    chk("b2b_no20", 28'(bad20), 28'd0);
    chk("b2b_30", {d4[3], d4[2], d4[1], d4[0]}, {7'h40, 7'h40, 7'h30, 7'h40});
    wr(8'd123, 2'd1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_disp", {d4[3], d4[2], d4[1], d4[0]}, {4{7'b1000000}});
    chk("rst_mid_busy", 28'(busy4), 28'd0);
    repeat (12) @(negedge clk);
    chk("rst_mid_hold", {d4[3], d4[2], d4[1], d4[0]}, {4{7'b1000000}});
    wr(8'd200, 2'd1, 1'b0);
    wait_idle(n);
    chk("d2_200", {14'b0, d2[1], d2[0]}, {14'b0, 7'h3F, 7'h3F});
    chk("d4_200", {d4[3], d4[2], d4[1], d4[0]}, {7'h40, 7'h24, 7'h40, 7'h40});
    wr(8'hF6, 2'd2, 1'b1);
    wait_idle(n);
    chk("d2_F6", {14'b0, d2[1], d2[0]}, {14'b0, 7'h3F, 7'h3F});
    chk("d4_F6", {d4[3], d4[2], d4[1], d4[0]}, {7'h7F, 7'h3F, 7'h79, 7'h40});
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 299) == 0;
      en = $urandom_range(0, 3) == 0;
      data = 8'($urandom);
      mode = 2'($urandom_range(0, 3));
      blz = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rst = 1'b0; en = 1'b0;
    repeat (30) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
